disaster_alert_scheduler: RTL and testbench

//  Sequential alarm controller behind the hazard-detect logic. Qualifies the four raw hazard

---
 rtl/disaster_pkg.sv | 23 ++
 rtl/hazard_persist.sv | 27 ++
 rtl/disaster_alert_scheduler.sv | 100 ++++++++++
 tb/tb_disaster_alert_scheduler.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/disaster_pkg.sv
// disaster_pkg: hazard indices, scheduler FSM states and priority/rotation helpers
package disaster_pkg;
   localparam int HAZ_FLOOD   = 0;
   localparam int HAZ_CYCLONE = 1;
   localparam int HAZ_QUAKE   = 2;
   localparam int HAZ_TSUNAMI = 3;
   localparam int NUM_HAZ     = 4;
   typedef logic [1:0] haz_idx_t;
   typedef enum logic [1:0] {IDLE, SHOW, NEXT} state_t;
   function automatic haz_idx_t prio_idx(input logic [NUM_HAZ-1:0] p);
      return p[HAZ_FLOOD] ? haz_idx_t'(HAZ_FLOOD) : p[HAZ_CYCLONE] ? haz_idx_t'(HAZ_CYCLONE) :
             p[HAZ_QUAKE] ? haz_idx_t'(HAZ_QUAKE) : haz_idx_t'(HAZ_TSUNAMI);
   endfunction
   // nearest pending index after c, wrapping; c itself only if it is the sole one
   function automatic haz_idx_t next_idx(input logic [NUM_HAZ-1:0] p, input haz_idx_t c);
      haz_idx_t k;
      next_idx = c;
      for (int i = NUM_HAZ; i >= 1; i--) begin
         k = c + haz_idx_t'(i);
         if (p[k]) next_idx = k;
      end
   endfunction
endpackage

// File: rtl/hazard_persist.sv
// hazard_persist: qualifies one raw hazard flag by tick persistence and latches it until cleared
module hazard_persist #(
   parameter int PERSIST = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_tick,
   input  logic i_raw,
   input  logic i_clr,
   output logic o_latched
);
   logic [3:0] r_cnt;
   logic       r_latched;
   logic       w_set;
   assign w_set = i_tick && i_raw && r_cnt >= 4'(PERSIST - 1);
   assign o_latched = r_latched;
   // a clear only acts on a latched or just-latching flag, and then wins over the latch
   always_ff @(posedge clk) begin
      if (rst || (i_clr && (r_latched || w_set))) begin
         r_cnt     <= '0;
         r_latched <= 1'b0;
      end else begin
         if (i_tick) r_cnt <= !i_raw ? '0 : r_cnt == 4'(PERSIST) ? r_cnt : r_cnt + 4'd1;
         if (w_set) r_latched <= 1'b1;
      end
   end
endmodule

// File: rtl/disaster_alert_scheduler.sv
// disaster_alert_scheduler: latches persistent hazards and schedules the LED/code display
// Optional buzzer output and pattern counter enabled by defining ALERT_BUZZER_EN.
module disaster_alert_scheduler
   import disaster_pkg::*;
#(
   parameter int PERSIST = 4,
   parameter int DWELL   = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [3:0] haz_raw,
   input  logic       mode,
   input  logic       ack_valid,
   input  logic [1:0] ack_idx,
   output logic [3:0] pending,
   output logic       alert_valid,
   output logic [1:0] alert_code,
   output logic [3:0] led
`ifdef ALERT_BUZZER_EN
   ,output logic      buzzer
`endif
);
   state_t     r_state, w_state;
   haz_idx_t   r_cur, w_cur;
   logic [7:0] r_dwell, w_dwell;
   logic       w_valid;
   logic [1:0] w_code;
   logic [3:0] w_led;
   for (genvar i = 0; i < NUM_HAZ; i++) begin : g_haz
      hazard_persist #(.PERSIST(PERSIST)) u_persist (
         .clk       (clk),
         .rst       (rst),
         .i_tick    (tick),
         .i_raw     (haz_raw[i]),
         .i_clr     (ack_valid && ack_idx == 2'(i)),
         .o_latched (pending[i])
      );
   end
   // outputs are registered from next-state values so led follows state with no extra lag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cur       <= '0;
         r_dwell     <= '0;
         alert_valid <= 1'b0;
         alert_code  <= '0;
         led         <= '0;
      end else begin
         r_state     <= w_state;
         r_cur       <= w_cur;
         r_dwell     <= w_dwell;
         alert_valid <= w_valid;
         alert_code  <= w_code;
         led         <= w_led;
      end
   end
   always_comb begin
      w_state = r_state;
      w_cur   = r_cur;
      w_dwell = r_dwell;
      case (r_state)
         IDLE: if (pending != '0) begin
            w_state = SHOW;
            w_cur   = prio_idx(pending);
            w_dwell = '0;
         end
         SHOW: if (pending == '0) w_state = IDLE;
            else if (!pending[r_cur]) w_state = NEXT;
            else if (!mode) begin
               w_cur   = prio_idx(pending);
               w_dwell = '0;
            end else if (tick) begin
               if (r_dwell == 8'(DWELL - 1)) w_state = NEXT;
               else w_dwell = r_dwell + 8'd1;
            end
         NEXT: begin
            w_state = pending == '0 ? IDLE : SHOW;
            w_cur   = next_idx(pending, r_cur);
            w_dwell = '0;
         end
         default: w_state = IDLE;
      endcase
   end
   always_comb begin
      w_valid = w_state == SHOW;
      w_code  = w_valid ? w_cur : '0;
      w_led   = w_valid ? 4'b0001 << w_cur : '0;
   end
`ifdef ALERT_BUZZER_EN
   logic [1:0] r_pat;
   always_ff @(posedge clk) begin
      if (rst || !alert_valid) r_pat <= '0;
      else if (tick) r_pat <= r_pat + 2'd1;
   end
   assign buzzer = alert_valid && (alert_code == 2'(HAZ_FLOOD) ? 1'b1 :
                                   alert_code == 2'(HAZ_CYCLONE) ? !r_pat[0] :
                                   alert_code == 2'(HAZ_QUAKE) ? !r_pat[1] : r_pat == 2'd0);
`endif
endmodule

// File: tb/tb_disaster_alert_scheduler.sv
// tb_disaster_alert_scheduler: vector table, hand sequences and random run against a reference model
module tb_disaster_alert_scheduler;
   localparam int PERSIST = 4;
   localparam int DWELL   = 8;
   logic       clk = 1'b0, rst = 1'b1, tick = 1'b0, mode = 1'b0, ack_valid = 1'b0;
   logic [3:0] haz_raw = '0;
   logic [1:0] ack_idx = '0;
   logic [3:0] pending, led;
   logic       alert_valid;
   logic [1:0] alert_code;
`ifdef ALERT_BUZZER_EN
   logic       buzzer;
`endif
   int n_tests = 0, n_fail = 0;
   always #5 clk = ~clk;
   disaster_alert_scheduler #(.PERSIST(PERSIST), .DWELL(DWELL)) dut (
      .clk(clk), .rst(rst), .tick(tick), .haz_raw(haz_raw), .mode(mode),
      .ack_valid(ack_valid), .ack_idx(ack_idx), .pending(pending),
      .alert_valid(alert_valid), .alert_code(alert_code), .led(led)
`ifdef ALERT_BUZZER_EN
      ,.buzzer(buzzer)
`endif
   );
   // reference model: run lengths per hazard and a display phase (0 off, 1 showing, 2 blank)
   int         m_run[4];
   logic [3:0] m_pend = '0;
   int         m_phase = 0, m_cur = 0, m_dwell = 0;
   function automatic int lowest(input logic [3:0] p);
      for (int i = 0; i < 4; i++) if (p[i]) return i;
      return 0;
   endfunction
   function automatic void model_step(input logic r, input logic t, input logic [3:0] raw,
                                      input logic md, input logic av, input logic [1:0] ai);
      logic [3:0] p;
      logic       set;
      p = m_pend;
      if (r) begin
         m_pend = '0; m_phase = 0; m_cur = 0; m_dwell = 0;
         for (int i = 0; i < 4; i++) m_run[i] = 0;
         return;
      end
      case (m_phase)
         0: if (p != 0) begin m_phase = 1; m_cur = lowest(p); m_dwell = 0; end
         1: if (p == 0) m_phase = 0;
            else if (!p[m_cur]) m_phase = 2;
            else if (!md) begin m_cur = lowest(p); m_dwell = 0; end
            else if (t) begin m_dwell++; if (m_dwell == DWELL) m_phase = 2; end
         default: begin
            m_phase = (p == 0) ? 0 : 1;
            m_dwell = 0;
            for (int k = 1; k <= 4; k++)
               if (p[(m_cur + k) % 4]) begin m_cur = (m_cur + k) % 4; break; end
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         set = t && raw[i] && (m_run[i] + 1 >= PERSIST);
         if (av && int'(ai) == i && (m_pend[i] || set)) begin
            m_pend[i] = 1'b0; m_run[i] = 0;
         end else begin
            if (t) m_run[i] = raw[i] ? m_run[i] + 1 : 0;
            if (set) m_pend[i] = 1'b1;
         end
      end
   endfunction
   function automatic logic [10:0] exp_vec(input logic [3:0] p, input logic [3:0] l);
      logic [1:0] c;
      c = l[1] ? 2'd1 : l[2] ? 2'd2 : l[3] ? 2'd3 : 2'd0;
      return {p, |l, c, l};
   endfunction
   function automatic logic [10:0] model_vec();
      return exp_vec(m_pend, m_phase == 1 ? 4'(1 << m_cur) : 4'b0000);
   endfunction
   function automatic logic [10:0] dut_out();
      return {pending, alert_valid, alert_code, led};
   endfunction
   function automatic void check(input string name, input logic [10:0] got, input logic [10:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got {pend,valid,code,led}=%h required=%h", name, got, exp);
      end
   endfunction
   task automatic apply(input logic r, input logic t, input logic [3:0] raw, input logic md,
                        input logic av, input logic [1:0] ai);
      rst = r; tick = t; haz_raw = raw; mode = md; ack_valid = av; ack_idx = ai;
      @(posedge clk);
      model_step(r, t, raw, md, av, ai);
      #1;
   endtask
   typedef struct {
      logic r, t; logic [3:0] raw; logic av; logic [1:0] ai; logic [10:0] exp;
   } vec_t;
   vec_t tbl[$];
   function automatic void add(input logic r, input logic t, input logic [3:0] raw, input logic av,
                               input logic [1:0] ai, input logic [3:0] p, input logic [3:0] l);
      vec_t v;
      v.r = r; v.t = t; v.raw = raw; v.av = av; v.ai = ai; v.exp = exp_vec(p, l);
      tbl.push_back(v);
   endfunction
   logic [3:0] r_raw = '0;
   logic       r_md = 1'b0;
   logic [3:0] exp_led;
   initial begin
      add(1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
      repeat (3) add(0, 1, 4'b0001, 0, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0000, 0, 0, 4'b0000, 4'b0000);
      repeat (3) add(0, 1, 4'b0001, 0, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0001, 0, 0, 4'b0001, 4'b0000);
      add(0, 0, 4'b0001, 0, 0, 4'b0001, 4'b0001);
      add(1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
      repeat (3) add(0, 1, 4'b1000, 0, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b1000, 0, 0, 4'b1000, 4'b0000);
      repeat (3) add(0, 1, 4'b1001, 0, 0, 4'b1000, 4'b1000);
      add(0, 1, 4'b1001, 0, 0, 4'b1001, 4'b1000);
      add(0, 0, 4'b1001, 0, 0, 4'b1001, 4'b0001);
      add(0, 0, 4'b1001, 1, 0, 4'b1000, 4'b0001);
      add(0, 0, 4'b1001, 0, 0, 4'b1000, 4'b0000);
      add(0, 0, 4'b1001, 0, 0, 4'b1000, 4'b1000);
      repeat (3) add(0, 1, 4'b1001, 0, 0, 4'b1000, 4'b1000);
      add(0, 1, 4'b1001, 0, 0, 4'b1001, 4'b1000);
      add(0, 0, 4'b1001, 0, 0, 4'b1001, 4'b0001);
      add(0, 0, 4'b1001, 1, 1, 4'b1001, 4'b0001);
      add(1, 0, 4'b0000, 0, 0, 4'b0000, 4'b0000);
      repeat (3) add(0, 1, 4'b0010, 0, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0010, 1, 1, 4'b0000, 4'b0000);
      repeat (3) add(0, 1, 4'b0010, 0, 0, 4'b0000, 4'b0000);
      add(0, 1, 4'b0010, 0, 0, 4'b0010, 4'b0000);
      add(0, 0, 4'b0010, 0, 0, 4'b0010, 4'b0010);
      foreach (tbl[i]) begin
         apply(tbl[i].r, tbl[i].t, tbl[i].raw, 1'b0, tbl[i].av, tbl[i].ai);
         check($sformatf("vec%0d", i), dut_out(), tbl[i].exp);
      end
      // rotate mode: flood and earthquake alternate, blank cycle between them
      apply(1, 0, 4'b0000, 1, 0, 0);
      repeat (PERSIST) apply(0, 1, 4'b0101, 1, 0, 0);
      check("rot_latch", dut_out(), exp_vec(4'b0101, 4'b0000));
      apply(0, 0, 4'b0101, 1, 0, 0);
      check("rot_first", dut_out(), exp_vec(4'b0101, 4'b0001));
      exp_led = 4'b0001;
      for (int r = 0; r < 3; r++) begin
         for (int k = 1; k <= DWELL; k++) begin
            apply(0, 1, 4'b0101, 1, 0, 0);
            check("rot_dwell", dut_out(), exp_vec(4'b0101, k < DWELL ? exp_led : 4'b0000));
            if (k < DWELL) begin
               apply(0, 0, 4'b0101, 1, 0, 0);
               check("rot_hold", dut_out(), exp_vec(4'b0101, exp_led));
            end
         end
         exp_led = (exp_led == 4'b0001) ? 4'b0100 : 4'b0001;
         apply(0, 0, 4'b0101, 1, 0, 0);
         check("rot_next", dut_out(), exp_vec(4'b0101, exp_led));
      end
      // reset while showing with every hazard latched
      apply(1, 0, 4'b0000, 0, 0, 0);
      repeat (PERSIST) apply(0, 1, 4'b1111, 0, 0, 0);
      apply(0, 0, 4'b1111, 0, 0, 0);
      check("all_show", dut_out(), exp_vec(4'b1111, 4'b0001));
      apply(1, 0, 4'b1111, 0, 0, 0);
      check("rst_mid", dut_out(), 11'd0);
      apply(0, 0, 4'b1111, 0, 0, 0);
      check("rst_after", dut_out(), 11'd0);
      // randomized run against the model
      apply(1, 0, 4'b0000, 0, 0, 0);
      for (int c = 0; c < 6000; c++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 15) == 0) r_raw[i] = ~r_raw[i];
         if ($urandom_range(0, 199) == 0) r_md = ~r_md;
         apply($urandom_range(0, 999) == 0, 1'($urandom_range(0, 1)), r_raw, r_md,
               $urandom_range(0, 11) == 0, 2'($urandom_range(0, 3)));
         check("rand", dut_out(), model_vec());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
